// File: rtl/p_encoder_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : p_encoder_rr_if
// Purpose  : Handshake bundle for the p_encoder_rr request encoder.
//            Input side : in_valid / in_ready / in / mode
//            Output side: out_valid / out_ready / out / onehot / zero
//            master = producer of requests and consumer of results (the
//            environment); slave = the encoder itself.
// Revision : 1.0  initial release
// ============================================================================
interface p_encoder_rr_if #(
  parameter int N = 8
) ();
  localparam int IW = $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out;
  logic [N-1:0]  onehot;
  logic          zero;

  modport master (
    output in_valid, in, mode, out_ready,
    input  in_ready, out_valid, out, onehot, zero
  );

  modport slave (
    input  in_valid, in, mode, out_ready,
    output in_ready, out_valid, out, onehot, zero
  );
endinterface
`default_nettype wire

// File: rtl/p_encoder_rr.sv
`default_nettype none
// ============================================================================
// Module   : p_encoder_rr
// Purpose  : N-input priority encoder with fixed (MSB-first) or round-robin
//            priority, registered output and valid/ready handshake on both
//            sides. One cycle latency, one vector per cycle throughput.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - p_encoder_rr_if.slave (request input / result output)
// Revision : 1.0  initial release
// ============================================================================
module p_encoder_rr #(
  parameter int N = 8
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  p_encoder_rr_if.slave   bus
);
  localparam int          IW        = $clog2(N);
  localparam logic [IW-1:0] c_PTR_MAX = IW'(N - 1);
  localparam logic [N-1:0]  c_ONE     = {{(N-1){1'b0}}, 1'b1};

  logic [IW-1:0] r_ptr;
  logic          r_out_valid;
  logic [IW-1:0] r_out;
  logic [N-1:0]  r_onehot;
  logic          r_zero;

  logic          w_accept;
  logic          w_consume;
  logic          w_any;
  logic [IW-1:0] w_fix_idx;
  logic [IW-1:0] w_rr_lo_idx;
  logic          w_rr_lo_any;
  logic [IW-1:0] w_grant;

  assign bus.in_ready  = !r_out_valid || bus.out_ready;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_consume     = r_out_valid && bus.out_ready;
  assign w_any         = |bus.in;

  // Highest set bit overall, and highest set bit at or below the pointer.
  // Round-robin order is ptr..0 then N-1..ptr+1: if anything is set in the
  // lower window it wins, otherwise the highest bit overall is necessarily
  // the first hit in the wrapped upper window.
  always_comb begin
    w_fix_idx   = '0;
    w_rr_lo_idx = '0;
    w_rr_lo_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.in[i]) begin
        w_fix_idx = IW'(i);
        if (IW'(i) <= r_ptr) begin
          w_rr_lo_idx = IW'(i);
          w_rr_lo_any = 1'b1;
        end
      end
    end
  end

  assign w_grant = (bus.mode && w_rr_lo_any) ? w_rr_lo_idx : w_fix_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= c_PTR_MAX;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_onehot    <= '0;
      r_zero      <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_zero      <= !w_any;
      r_out       <= w_any ? w_grant : '0;
      r_onehot    <= w_any ? (c_ONE << w_grant) : '0;
      // Granted source drops to lowest priority; wrap is explicit at N-1.
      if (bus.mode && w_any) begin
        r_ptr <= (w_grant == '0) ? c_PTR_MAX : (w_grant - IW'(1));
      end
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.onehot    = r_onehot;
  assign bus.zero      = r_zero;
endmodule
`default_nettype wire

// File: tb/tb_p_encoder_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_p_encoder_rr
// Purpose  : Directed self-checking bench for p_encoder_rr (N=4 and N=5).
// Revision : 1.0  initial release
// ============================================================================
module tb_p_encoder_rr;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  p_encoder_rr_if #(.N(4)) bus4 ();
  p_encoder_rr_if #(.N(5)) bus5 ();

  p_encoder_rr #(.N(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  p_encoder_rr #(.N(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a vector on the N=4 port, clock it in, check the result 1 cycle later.
  task automatic acc4(input string tag, input logic [3:0] v, input logic m,
                      input int exp_out, input logic exp_zero);
    logic [3:0] oh;
    bus4.in_valid = 1'b1;
    bus4.in       = v;
    bus4.mode     = m;
    @(posedge clk); #1;
    oh = exp_zero ? 4'b0000 : (4'b0001 << exp_out);
    chk_eq({tag, ".valid"},  32'(bus4.out_valid), 32'd1);
    chk_eq({tag, ".out"},    32'(bus4.out),       32'(exp_out));
    chk_eq({tag, ".onehot"}, 32'(bus4.onehot),    32'(oh));
    chk_eq({tag, ".zero"},   32'(bus4.zero),      32'(exp_zero));
  endtask

  task automatic acc5(input string tag, input logic [4:0] v, input int exp_out);
    bus5.in_valid = 1'b1;
    bus5.in       = v;
    bus5.mode     = 1'b1;
    @(posedge clk); #1;
    chk_eq({tag, ".valid"}, 32'(bus5.out_valid), 32'd1);
    chk_eq({tag, ".out"},   32'(bus5.out),       32'(exp_out));
  endtask

  // Async reset pulse placed between clock edges (called at posedge+1).
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk_eq("rst.async4.valid", 32'(bus4.out_valid), 32'd0);
    chk_eq("rst.async5.valid", 32'(bus5.out_valid), 32'd0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus4.in_valid = 1'b0; bus4.in = '0; bus4.mode = 1'b0; bus4.out_ready = 1'b1;
    bus5.in_valid = 1'b0; bus5.in = '0; bus5.mode = 1'b0; bus5.out_ready = 1'b1;

    // Reset state
    #12;
    chk_eq("rst.valid",  32'(bus4.out_valid), 32'd0);
    chk_eq("rst.out",    32'(bus4.out),       32'd0);
    chk_eq("rst.onehot", 32'(bus4.onehot),    32'd0);
    chk_eq("rst.zero",   32'(bus4.zero),      32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_eq("rst.in_ready", 32'(bus4.in_ready), 32'd1);

    // Fixed priority, back-to-back
    acc4("fix0", 4'b0101, 1'b0, 2, 1'b0);
    acc4("fix1", 4'b1011, 1'b0, 3, 1'b0);
    acc4("fix2", 4'b0110, 1'b0, 2, 1'b0);
    acc4("fix3", 4'b0010, 1'b0, 1, 1'b0);
    acc4("fix4", 4'b0001, 1'b0, 0, 1'b0);
    acc4("fix5", 4'b1010, 1'b0, 3, 1'b0);

    // Round-robin from reset pointer (N-1)
    mid_reset();
    acc4("rr0", 4'b1111, 1'b1, 3, 1'b0);
    acc4("rr1", 4'b1111, 1'b1, 2, 1'b0);
    acc4("rr2", 4'b1111, 1'b1, 1, 1'b0);
    acc4("rr3", 4'b1111, 1'b1, 0, 1'b0);
    acc4("rr4", 4'b1111, 1'b1, 3, 1'b0);
    acc4("rr5", 4'b1111, 1'b1, 2, 1'b0);   // ptr was 2 -> now 1
    acc4("rr6", 4'b0010, 1'b1, 1, 1'b0);   // grant 1 -> ptr 0
    acc4("rrw0", 4'b1010, 1'b1, 3, 1'b0);  // wrap past 0 -> ptr 2
    acc4("rrw1", 4'b1010, 1'b1, 1, 1'b0);  // ptr 0

    // Zero vectors leave ptr alone; fixed accepts leave ptr alone
    acc4("zr1", 4'b0000, 1'b1, 0, 1'b1);
    acc4("zr1n", 4'b1000, 1'b1, 3, 1'b0);  // ptr 0 -> wrap to 3, ptr 2
    acc4("zr0", 4'b0000, 1'b0, 0, 1'b1);
    acc4("fixp", 4'b0001, 1'b0, 0, 1'b0);
    acc4("mode", 4'b0110, 1'b1, 2, 1'b0);  // ptr still 2 -> ptr 1

    // Backpressure holding out=2
    bus4.out_ready = 1'b0;
    bus4.in = 4'b1000; bus4.mode = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk_eq("bp.out",      32'(bus4.out),       32'd2);
      chk_eq("bp.in_ready", 32'(bus4.in_ready),  32'd0);
      chk_eq("bp.valid",    32'(bus4.out_valid), 32'd1);
      bus4.in = 4'(c + 1);
    end
    bus4.out_ready = 1'b1;
    bus4.in = 4'b0001;
    #1;
    chk_eq("bp.release_ready", 32'(bus4.in_ready), 32'd1);
    @(posedge clk); #1;
    chk_eq("bp.next.out",   32'(bus4.out),       32'd0);
    chk_eq("bp.next.valid", 32'(bus4.out_valid), 32'd1);

    // Consume without accept; idle input content ignored
    bus4.in_valid = 1'b0;
    bus4.in = 4'bxxxx;
    @(posedge clk); #1;
    chk_eq("drain.valid", 32'(bus4.out_valid), 32'd0);
    chk_eq("drain.out",   32'(bus4.out),       32'd0);
    @(posedge clk); #1;
    chk_eq("idle.valid",  32'(bus4.out_valid), 32'd0);
    acc4("idle.ptr", 4'b1111, 1'b1, 1, 1'b0); // ptr 1 untouched -> ptr 0

    // Reset mid-run with a pending result
    mid_reset();
    acc4("rstp", 4'b1111, 1'b1, 3, 1'b0);
    bus4.in_valid = 1'b0;

    // N=5: move pointer, reset mid-run, then full rotation with wrap 0 -> 4
    acc5("n5a", 5'b11111, 4);
    acc5("n5b", 5'b11111, 3);
    mid_reset();
    acc5("n5r0", 5'b11111, 4);
    acc5("n5r1", 5'b11111, 3);
    acc5("n5r2", 5'b11111, 2);
    acc5("n5r3", 5'b11111, 1);
    acc5("n5r4", 5'b11111, 0);
    acc5("n5wr", 5'b11111, 4);
    acc5("n5sp", 5'b00001, 0);             // ptr 3: search 3..0 -> 0, ptr 4
    acc5("n5hi", 5'b10001, 4);
    bus5.in_valid = 1'b0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
